// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package Dmem_arb_types;

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic {LS_PRIO, EXT_BURST} Arb_state;

  typedef enum logic [1:0] {OWNER_NONE, OWNER_LS, OWNER_EXT} Mem_owner;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic [CNT_WIDTH-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_return_tracker.sv
// Remembers who owned memory last cycle and steers the 1-cycle-late read data.
module dmem_return_tracker
  import Dmem_arb_types::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ls_gnt,
  input  logic                  i_ext_gnt,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_ext_rvalid,
  output logic [DATA_WIDTH-1:0] o_ext_rdata,
  output logic [DATA_WIDTH-1:0] o_ls_rdata
);

  Mem_owner r_owner;
  logic     r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWNER_NONE;
      r_rd    <= 1'b0;
    end else begin
      if (i_ext_gnt)     r_owner <= OWNER_EXT;
      else if (i_ls_gnt) r_owner <= OWNER_LS;
      else               r_owner <= OWNER_NONE;
      r_rd <= (i_ext_gnt | i_ls_gnt) & ~i_we;
    end
  end

  always_comb begin
    o_ext_rvalid = (r_owner == OWNER_EXT) & r_rd;
    o_ext_rdata  = o_ext_rvalid ? i_mem_rdata : '0;
    // ls return is gated by ownership only; the pipeline knows whether it issued a read
    o_ls_rdata   = (r_owner == OWNER_LS) ? i_mem_rdata : '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between load/store and an external port,
// with starvation forcing and bounded locked bursts for the external side.
module dmem_arbiter
  import Dmem_arb_types::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ls_en,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [3:0]            ls_be,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_stall,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  input  logic                  ext_req,
  input  logic                  ext_lock,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [3:0]            ext_be,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] STARVE_LIM = CNT_WIDTH'(MAX_STARVE);
  localparam logic [CNT_WIDTH-1:0] BURST_LIM  = CNT_WIDTH'(MAX_BURST);

  Arb_state               r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_starve, w_starve_nxt;
  logic [CNT_WIDTH-1:0]   r_burst, w_burst_nxt, w_burst_inc;
  logic                   w_ext_gnt, w_ls_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= LS_PRIO;
      r_starve <= '0;
      r_burst  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_burst  <= w_burst_nxt;
    end
  end

  always_comb begin
    w_ext_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_burst_inc = r_burst + 1'b1;
    case (r_state)
      LS_PRIO: begin
        w_ext_gnt = ext_req & (~ls_en | (r_starve == STARVE_LIM));
        if (w_ext_gnt && ext_lock && (MAX_BURST > 1)) begin
          w_state_nxt = EXT_BURST;
          w_burst_nxt = CNT_WIDTH'(1);
        end
      end
      EXT_BURST: begin
        w_ext_gnt = ext_req;
        if (!ext_req || !ext_lock || (w_burst_inc >= BURST_LIM)) begin
          w_state_nxt = LS_PRIO;
          w_burst_nxt = '0;
        end else begin
          w_burst_nxt = w_burst_inc;
        end
      end
      default: begin
        w_state_nxt = LS_PRIO;
        w_burst_nxt = '0;
      end
    endcase
    w_ls_gnt     = ls_en & ~w_ext_gnt;
    w_starve_nxt = (ext_req && !w_ext_gnt) ? sat_inc(r_starve, STARVE_LIM) : '0;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (w_ext_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_be    = ext_be;
      mem_wdata = ext_wdata;
    end else if (w_ls_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_be    = ls_be;
      mem_wdata = ls_wdata;
    end
  end

  assign ext_gnt  = w_ext_gnt;
  assign ls_stall = ls_en & ~w_ls_gnt;

  dmem_return_tracker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ret (
    .clk         (clk),
    .reset       (reset),
    .i_ls_gnt    (w_ls_gnt),
    .i_ext_gnt   (w_ext_gnt),
    .i_we        (mem_we),
    .i_mem_rdata (mem_rdata),
    .o_ext_rvalid(ext_rvalid),
    .o_ext_rdata (ext_rdata),
    .o_ls_rdata  (ls_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MS = 4;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ls_en, ls_we, ls_stall;
  logic [AW-1:0] ls_addr;
  logic [3:0]    ls_be;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          ext_req, ext_lock, ext_we, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_addr;
  logic [3:0]    ext_be;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_STARVE(MS),
    .MAX_BURST (MB)
  ) dut (
    .clk(clk), .reset(reset),
    .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_be(ls_be), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_rdata(ls_rdata),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_be(ext_be), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment RAM: 1-cycle read latency, returns the pre-write word on any access
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] ram_q = '0;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      ram_q <= ram[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model
  logic [DW-1:0] shadow [1024];
  int            m_starve;
  bit            m_burst;
  int            m_bcnt;
  int            m_owner;   // 0 none, 1 ls, 2 ext
  bit            m_rd;
  logic [DW-1:0] m_data;

  int n_checks = 0;
  int n_errors = 0;

  logic          s_ext_gnt, s_ls_stall, s_ext_rvalid, s_mem_en, s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_mem_be;
  logic [DW-1:0] s_ext_rdata, s_ls_rdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit chk);
    bit            eg, lg, we;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [DW-1:0] wd;
    #2;
    eg = m_burst ? ext_req : (ext_req && (!ls_en || m_starve >= MS));
    lg = ls_en && !eg;
    we = eg ? ext_we : ls_we;
    a  = eg ? ext_addr : ls_addr;
    be = eg ? ext_be : ls_be;
    wd = eg ? ext_wdata : ls_wdata;
    s_ext_gnt = ext_gnt; s_ls_stall = ls_stall; s_ext_rvalid = ext_rvalid;
    s_ext_rdata = ext_rdata; s_ls_rdata = ls_rdata; s_mem_en = mem_en;
    s_mem_we = mem_we; s_mem_addr = mem_addr; s_mem_be = mem_be;
    if (chk) begin
      check("ext_gnt", ext_gnt, eg);
      check("ls_stall", ls_stall, ls_en && !lg);
      check("mem_en", mem_en, eg || lg);
      check("mem_we", mem_we, (eg || lg) ? we : 1'b0);
      check("mem_addr", mem_addr, (eg || lg) ? a : '0);
      check("mem_be", mem_be, (eg || lg) ? be : '0);
      check("mem_wdata", mem_wdata, (eg || lg) ? wd : '0);
      check("ext_rvalid", ext_rvalid, m_owner == 2 && m_rd);
      check("ext_rdata", ext_rdata, (m_owner == 2 && m_rd) ? m_data : '0);
      check("ls_rdata", ls_rdata, (m_owner == 1) ? m_data : '0);
    end
    if (eg || lg) begin
      m_data  = shadow[a];
      m_owner = eg ? 2 : 1;
      m_rd    = !we;
      if (we)
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
    end else begin
      m_owner = 0;
      m_rd    = 0;
    end
    m_starve = (!ext_req || eg) ? 0 : ((m_starve + 1 > MS) ? MS : m_starve + 1);
    if (!m_burst) begin
      if (eg && ext_lock && MB > 1) begin
        m_burst = 1;
        m_bcnt  = 1;
      end
    end else if (!ext_req) begin
      m_burst = 0;
    end else begin
      m_bcnt++;
      if (!ext_lock || m_bcnt >= MB) m_burst = 0;
    end
    if (reset) begin
      m_burst = 0; m_bcnt = 0; m_starve = 0; m_owner = 0; m_rd = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ls(input bit en, input bit we, input int addr, input logic [3:0] be,
                        input logic [DW-1:0] wd);
    ls_en = en; ls_we = we; ls_addr = AW'(addr); ls_be = be; ls_wdata = wd;
  endtask

  task automatic set_ext(input bit req, input bit lock, input bit we, input int addr,
                         input logic [3:0] be, input logic [DW-1:0] wd);
    ext_req = req; ext_lock = lock; ext_we = we; ext_addr = AW'(addr); ext_be = be;
    ext_wdata = wd;
  endtask

  task automatic idle();
    set_ls(0, 0, 0, 4'h0, '0);
    set_ext(0, 0, 0, 0, 4'h0, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 32'h1000_0000 + 32'(i) * 32'h0001_0001;
      shadow[i] = ram[i];
    end
    ram[16] = 32'hDEAD_BEEF;
    shadow[16] = 32'hDEAD_BEEF;
    m_starve = 0; m_burst = 0; m_bcnt = 0; m_owner = 0; m_rd = 0; m_data = '0;

    reset = 1'b1;
    idle();
    tick(0);
    tick(0);
    reset = 1'b0;

    // reset state
    tick(1);
    check("rst_ext_rvalid", s_ext_rvalid, 1'b0);
    check("rst_ls_rdata", s_ls_rdata, '0);
    check("rst_mem_en", s_mem_en, 1'b0);

    // lone ls read
    set_ls(1, 0, 16, 4'hF, '0);
    tick(1);
    check("ls_rd_mem_en", s_mem_en, 1'b1);
    check("ls_rd_stall", s_ls_stall, 1'b0);
    idle();
    tick(1);
    check("ls_rd_data", s_ls_rdata, 32'hDEAD_BEEF);
    check("ls_rd_no_ext_rvalid", s_ext_rvalid, 1'b0);

    // starvation forcing
    set_ls(1, 0, 32, 4'hF, '0);
    set_ext(1, 0, 0, 48, 4'hF, '0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("starve_gnt", s_ext_gnt, i == 4);
      check("starve_stall", s_ls_stall, i == 4);
      if (i == 5) check("starve_rvalid", s_ext_rvalid, 1'b1);
    end
    idle();
    tick(1);

    // locked burst bounded at MAX_BURST
    set_ls(1, 0, 33, 4'hF, '0);
    set_ext(1, 1, 0, 49, 4'hF, '0);
    for (int i = 0; i < 14; i++) begin
      tick(1);
      check("burst_gnt", s_ext_gnt, i >= MS && i < MS + MB);
      check("burst_stall", s_ls_stall, i >= MS && i < MS + MB);
    end
    idle();
    tick(1);

    // burst aborted by ext_req drop
    set_ext(1, 1, 0, 50, 4'hF, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("abort_gnt", s_ext_gnt, 1'b1);
    end
    set_ext(0, 1, 0, 50, 4'hF, '0);
    set_ls(1, 0, 34, 4'hF, '0);
    tick(1);
    check("abort_ls_gnt", s_ls_stall, 1'b0);
    set_ext(1, 1, 0, 50, 4'hF, '0);
    tick(1);
    check("abort_back_prio", s_ext_gnt, 1'b0);
    idle();
    tick(1);

    // ext partial write at top address
    set_ext(1, 0, 1, 32'h3FF, 4'b0011, 32'h0000_ABCD);
    tick(1);
    check("ewr_we", s_mem_we, 1'b1);
    check("ewr_be", s_mem_be, 4'b0011);
    check("ewr_addr", s_mem_addr, 10'h3FF);
    set_ext(1, 0, 0, 32'h3FF, 4'hF, '0);
    tick(1);
    check("ewr_no_rvalid", s_ext_rvalid, 1'b0);
    idle();
    tick(1);
    check("ewr_readback", s_ext_rdata, 32'h13FF_ABCD);

    // reset during burst with a read in flight
    set_ext(1, 1, 0, 64, 4'hF, '0);
    tick(1);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    idle();
    tick(1);
    check("rstb_rvalid", s_ext_rvalid, 1'b0);
    set_ls(1, 0, 65, 4'hF, '0);
    set_ext(1, 1, 0, 66, 4'hF, '0);
    tick(1);
    check("rstb_ls_prio", s_ext_gnt, 1'b0);
    idle();
    tick(1);

    // randomized traffic; a stalled ls request is held unchanged
    for (int i = 0; i < 800; i++) begin
      if (!(ls_en && s_ls_stall))
        set_ls($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? 32'h3F0 + $urandom_range(0, 15)
                                          : $urandom_range(0, 15),
               4'($urandom_range(0, 15)), $urandom);
      set_ext($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 70,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15),
              4'($urandom_range(0, 15)), $urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    reset = 1'b0;
    idle();
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (Ram_if, 1-cycle read latency) between the pipeline's load/store unit and a secondary bus requester (external host / DMA port).
- Load/store has priority by default.
- A starvation counter and a bounded lock/burst mode guarantee forward progress for the secondary port.
- When the secondary port owns memory during a pipeline access, the arbiter stalls the pipeline.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data memory.
- DATA_WIDTH, 32, data word width.
- MAX_STARVE, 4, consecutive denied ext cycles before ext is forced a grant (1..15).
- MAX_BURST, 8, maximum consecutive locked ext grants (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ls_en  in  1  load/store access request this cycle.
- ls_we  in  1  load/store write.
- ls_addr  in  ADDR_WIDTH  load/store word address.
- ls_be  in  4  load/store byte enables.
- ls_wdata  in  DATA_WIDTH  load/store write data.
- ls_stall  out  1  ls_en present but not granted; pipeline must hold the request.
- ls_rdata  out  DATA_WIDTH  read data, valid one cycle after a granted ls read.
- ext_req  in  1  secondary request.
- ext_lock  in  1  request continued ownership (burst) next cycle.
- ext_we  in  1  secondary write.
- ext_addr  in  ADDR_WIDTH  secondary word address.
- ext_be  in  4  secondary byte enables.
- ext_wdata  in  DATA_WIDTH  secondary write data.
- ext_gnt  out  1  secondary access accepted this cycle.
- ext_rvalid  out  1  ext_rdata valid (one cycle after a granted ext read).
- ext_rdata  out  DATA_WIDTH  secondary read data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_be  out  4  memory byte enables.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data (1-cycle latency).

Behaviour:
- Grant is combinational from current state and requests; mem_* is muxed from the granted source.
- With no grant: mem_en=0, mem_we=0, other mem_* = 0.
- State LS_PRIO:
  - Ext is granted if ext_req and (!ls_en or starve_cnt==MAX_STARVE); otherwise ls is granted if ls_en.
  - If ext is granted with ext_lock=1 and MAX_BURST>1: next state EXT_BURST, burst_cnt=1.
- State EXT_BURST:
  - Ext is granted if ext_req, and burst_cnt increments.
  - Return to LS_PRIO when ext_req=0, ext_lock=0 on a grant, or burst_cnt reaches MAX_BURST after the grant.
  - The return does not depend on ls_en.
- ls_stall = ls_en & ~ls_granted. Ls sees only stall; it must hold its request.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) each cycle ext_req=1 and ext_gnt=0.
  - Clears on ext_gnt or when ext_req=0.
  - It is 4 bits wide.
- Read return:
  - Registered owner_d ∈ {NONE, LS, EXT} and rd_d = granted & ~we.
  - ext_rvalid = (owner_d==EXT) & rd_d.
  - ext_rdata = mem_rdata when ext_rvalid, else 0.
  - ls_rdata = mem_rdata when owner_d==LS, else 0.
- Writes produce no rvalid.
- A write and a read from different sources in consecutive cycles are independent; no turnaround bubble.
- Simultaneous requests in LS_PRIO with starve_cnt<MAX_STARVE: ls wins.
- ext_req dropped while in EXT_BURST: no grant, state returns to LS_PRIO the same cycle; a combinationally pending ls is granted.
- Reset values: state LS_PRIO, starve_cnt=0, burst_cnt=0, owner_d=NONE, rd_d=0.
  - Hence ext_rvalid=0 and ls_rdata=0 in the cycle after reset.
  - Reset mid-burst or with a read in flight discards the pending return.
- Outputs ls_stall, ext_gnt and mem_* are combinational and follow inputs once out of reset.

Decomposition:
- Package Dmem_arb_types: typedef enum Arb_state {LS_PRIO, EXT_BURST}; typedef enum Mem_owner {OWNER_NONE, OWNER_LS, OWNER_EXT}; counter-width constant CNT_WIDTH=4.
- One sub-module: dmem_return_tracker. It holds owner_d/rd_d and generates ext_rvalid, ext_rdata and ls_rdata.
- The grant logic and FSM stay in dmem_arbiter.

Test Plan:
- Only ls_en=1, read addr 0x010, mem returns 0xDEADBEEF → mem_en=1 same cycle, ls_stall=0; next cycle ls_rdata=0xDEADBEEF, ext_rvalid=0.
- ls_en and ext_req both held high, ext_lock=0, MAX_STARVE=4 → ls granted cycles 0-3; cycle 4 ext_gnt=1, ls_stall=1; starve_cnt returns to 0; ext read returns ext_rvalid=1 at cycle 5.
- ext_req, ext_lock held 1, ls_en=1, starve forced, MAX_BURST=8 → exactly 8 consecutive ext_gnt cycles with ls_stall=1, then ls granted.
- EXT_BURST with ext_req dropped after 3 grants → LS_PRIO the same cycle; ls granted that cycle.
- Ext write addr 0x3FF, be=4'b0011, data 0x0000ABCD, ls idle → mem_we=1, mem_be=0011, mem_addr=0x3FF; no ext_rvalid next cycle.
- Reset asserted during a burst with an ext read in flight → ext_rvalid=0 the next cycle; state LS_PRIO; starve_cnt=0.
